// File: rtl/fir_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel FIR.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fir_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MAC   = 2'd2,
    ST_OUT   = 2'd3
  } fir_state_e;

  // Working width for the round/saturate step; wide enough for any sane ACC_W.
  localparam int SCALE_W = 128;

  // Ceiling log2, never below 1 so that single-entry fields still get a bit.
  function automatic int fir_clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Accumulator sized so that N full-scale products can never overflow.
  function automatic int fir_acc_w(input int data_w, input int coef_w, input int n);
    return data_w + coef_w + fir_clog2(n);
  endfunction

  // Round half-up then arithmetic shift (only when shift>0), then clamp to a
  // signed data_w-bit range. Caller truncates the result to data_w bits.
  function automatic logic signed [SCALE_W-1:0] fir_round_sat(
    input logic signed [SCALE_W-1:0] acc,
    input int                        shift,
    input int                        data_w
  );
    logic signed [SCALE_W-1:0] one;
    logic signed [SCALE_W-1:0] r;
    logic signed [SCALE_W-1:0] hi;
    logic signed [SCALE_W-1:0] lo;
    one = SCALE_W'(1);
    r   = acc;
    if (shift > 0) r = (acc + (one <<< (shift - 1))) >>> shift;
    hi = (one <<< (data_w - 1)) - one;
    lo = -(one <<< (data_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
// Latency: read data valid one cycle after raddr is presented.
// Backpressure: none; write and read every cycle. Ports: clk, we/waddr/wdata, raddr/rdata.
module fir_sdp_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset: coefficients must survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_mc_seq.sv
// Multi-channel FIR with one shared MAC, shared coefficient RAM and per-channel history RAM.
// Latency: m_valid rises N+2 cycles after the accepting edge; one sample in flight at a time.
// Backpressure: s_ready only in IDLE without coef_we; result held in OUT until m_ready.
// Ports: s_* sample stream in, m_* result stream out, coef_* tap writes, clear/busy/chan_err status.
module fir_mc_seq
  import fir_pkg::*;
#(
  parameter int  N      = 11,
  parameter int  DATA_W = 32,
  parameter int  COEF_W = 16,
  parameter int  CH     = 2,
  parameter int  SHIFT  = 0,
  localparam int CW     = fir_clog2(CH),
  localparam int CAW    = fir_clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [CW-1:0]            s_chan,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic [CW-1:0]            m_chan,
  input  logic                     coef_we,
  input  logic [CAW-1:0]           coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     busy,
  output logic                     chan_err
);

  localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, N);
  localparam int HD    = CH * N;
  localparam int HAW   = fir_clog2(HD);
  localparam int TW    = fir_clog2(N + 2);
  localparam int PW    = DATA_W + COEF_W;

  fir_state_e              state_q, state_d;
  logic [TW-1:0]           tap_q;
  logic [HAW-1:0]          clr_q;
  logic [CAW-1:0]          ptr_q [CH];
  logic [CW-1:0]           chan_q;
  logic signed [ACC_W-1:0] acc_q;

  logic                    take, chan_ok, accept;
  logic                    h_we, c_we;
  logic [HAW-1:0]          h_waddr, h_raddr;
  logic [DATA_W-1:0]       h_wdata, h_rdata;
  logic [CAW-1:0]          c_raddr;
  logic [COEF_W-1:0]       c_rdata;
  logic signed [PW-1:0]    prod;
  int                      rd_idx;

  assign take    = s_valid && s_ready;
  assign chan_ok = 32'(s_chan) < CH;
  assign accept  = take && chan_ok;
  assign prod    = $signed({{COEF_W{h_rdata[DATA_W-1]}}, h_rdata}) *
                   $signed({{DATA_W{c_rdata[COEF_W-1]}}, c_rdata});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  // Next state; clear overrides everything, including a sweep already running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (32'(clr_q) == HD - 1) state_d = ST_IDLE;
      ST_IDLE:  if (accept) state_d = ST_MAC;
      ST_MAC:   if (32'(tap_q) == N + 1) state_d = ST_OUT;
      ST_OUT:   if (m_ready) state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
    if (clear) state_d = ST_CLEAR;
  end

  // Outputs and RAM port control
  always_comb begin
    s_ready = (state_q == ST_IDLE) && !coef_we;
    busy    = (state_q != ST_IDLE);
    m_valid = (state_q == ST_OUT);
    h_we    = 1'b0;
    h_waddr = '0;
    h_wdata = '0;
    h_raddr = '0;
    c_we    = 1'b0;
    c_raddr = '0;
    rd_idx  = 0;
    case (state_q)
      ST_CLEAR: begin
        h_we    = 1'b1;
        h_waddr = clr_q;
      end
      ST_IDLE: begin
        h_we    = accept;
        h_waddr = HAW'(int'(s_chan) * N + int'(ptr_q[s_chan]));
        h_wdata = s_data;
        c_we    = coef_we && (32'(coef_addr) < N);
      end
      ST_MAC: begin
        // Tap k reads the sample k steps older than the newest one (circular).
        if (32'(tap_q) < N) begin
          rd_idx = int'(ptr_q[chan_q]) - int'(tap_q);
          if (rd_idx < 0) rd_idx = rd_idx + N;
          h_raddr = HAW'(int'(chan_q) * N + rd_idx);
          c_raddr = tap_q[CAW-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath: tap counter, sweep counter, pointers, accumulator, result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q    <= '0;
      clr_q    <= '0;
      chan_q   <= '0;
      acc_q    <= '0;
      m_data   <= '0;
      m_chan   <= '0;
      chan_err <= 1'b0;
      for (int i = 0; i < CH; i++) ptr_q[i] <= '0;
    end else begin
      chan_err <= (state_q == ST_IDLE) && take && !chan_ok && !clear;
      if (clear) begin
        clr_q <= '0;
        for (int i = 0; i < CH; i++) ptr_q[i] <= '0;
      end else begin
        case (state_q)
          ST_CLEAR: clr_q <= clr_q + 1'b1;
          ST_IDLE: begin
            if (accept) begin
              chan_q <= s_chan;
              tap_q  <= '0;
              acc_q  <= '0;
            end
          end
          ST_MAC: begin
            tap_q <= tap_q + 1'b1;
            // RAM data for read issued at tap k arrives while tap_q == k+1.
            if (tap_q != '0 && 32'(tap_q) <= N) acc_q <= acc_q + ACC_W'(prod);
            if (32'(tap_q) == N + 1) begin
              m_data <= DATA_W'(fir_round_sat(SCALE_W'(acc_q), SHIFT, DATA_W));
              m_chan <= chan_q;
            end
          end
          ST_OUT: begin
            if (m_ready) begin
              ptr_q[chan_q] <= (32'(ptr_q[chan_q]) == N - 1) ? '0 : ptr_q[chan_q] + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  fir_sdp_ram #(.DEPTH(N), .WIDTH(COEF_W), .AW(CAW)) u_coef_ram (
    .clk   (clk),
    .we    (c_we),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .raddr (c_raddr),
    .rdata (c_rdata)
  );

  fir_sdp_ram #(.DEPTH(HD), .WIDTH(DATA_W), .AW(HAW)) u_hist_ram (
    .clk   (clk),
    .we    (h_we),
    .waddr (h_waddr),
    .wdata (h_wdata),
    .raddr (h_raddr),
    .rdata (h_rdata)
  );

endmodule

// File: tb/tb_fir_mc_seq.sv
`timescale 1ns/1ps
module tb_fir_mc_seq;

  localparam int N = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: N=11, CH=2, DATA_W=32, COEF_W=16, SHIFT=0
  logic               a_clear, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
  logic               a_coef_we, a_busy, a_chan_err;
  logic [31:0]        a_s_data;
  logic signed [31:0] a_m_data;
  logic               a_s_chan, a_m_chan;
  logic [3:0]         a_coef_addr;
  logic [15:0]        a_coef_wdata;

  // DUT B: N=11, CH=3, DATA_W=16, COEF_W=16, SHIFT=2
  logic               b_clear, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
  logic               b_coef_we, b_busy, b_chan_err;
  logic [15:0]        b_s_data;
  logic signed [15:0] b_m_data;
  logic [1:0]         b_s_chan, b_m_chan;
  logic [3:0]         b_coef_addr;
  logic [15:0]        b_coef_wdata;

  fir_mc_seq #(.N(N), .DATA_W(32), .COEF_W(16), .CH(2), .SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_chan(a_s_chan),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_chan(a_m_chan),
    .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_wdata(a_coef_wdata),
    .busy(a_busy), .chan_err(a_chan_err)
  );

  fir_mc_seq #(.N(N), .DATA_W(16), .COEF_W(16), .CH(3), .SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_chan(b_s_chan),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_chan(b_m_chan),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_wdata(b_coef_wdata),
    .busy(b_busy), .chan_err(b_chan_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: taps, and per-channel history with index 0 = newest sample.
  int     cf [N] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
  longint coef_a [N];
  longint coef_b [N];
  longint hist_a [2][N];
  longint hist_b [3][N];

  function automatic longint fir_ref(input longint h [N], input longint c [N],
                                     input int shift, input int dw);
    longint acc;
    longint hi;
    longint lo;
    acc = 0;
    for (int k = 0; k < N; k++) acc += h[k] * c[k];
    if (shift > 0) acc = (acc + (longint'(1) << (shift - 1))) >>> shift;
    hi = (longint'(1) << (dw - 1)) - 1;
    lo = -(longint'(1) << (dw - 1));
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic zero_hist();
    for (int c = 0; c < 2; c++) for (int k = 0; k < N; k++) hist_a[c][k] = 0;
    for (int c = 0; c < 3; c++) for (int k = 0; k < N; k++) hist_b[c][k] = 0;
  endtask

  task automatic load_a(input int addr, input longint v);
    a_coef_we = 1'b1; a_coef_addr = addr[3:0]; a_coef_wdata = v[15:0];
    tick();
    a_coef_we = 1'b0;
    if (addr < N) coef_a[addr] = longint'($signed(v[15:0]));
  endtask

  task automatic load_b(input int addr, input longint v);
    b_coef_we = 1'b1; b_coef_addr = addr[3:0]; b_coef_wdata = v[15:0];
    tick();
    b_coef_we = 1'b0;
    if (addr < N) coef_b[addr] = longint'($signed(v[15:0]));
  endtask

  task automatic wait_ready_a();
    int t;
    t = 0;
    while (!a_s_ready && t < 100) begin tick(); t++; end
    check("a_s_ready_idle", a_s_ready, 1);
  endtask

  task automatic send_a(input int ch, input longint x, input int stall,
                        input bit mac_coef, output longint got);
    int     t;
    longint exp_v;
    longint h [N];
    wait_ready_a();
    a_s_valid = 1'b1; a_s_chan = ch[0]; a_s_data = x[31:0];
    tick();
    a_s_valid = 1'b0;
    for (int k = N - 1; k > 0; k--) hist_a[ch][k] = hist_a[ch][k-1];
    hist_a[ch][0] = longint'($signed(a_s_data));
    for (int k = 0; k < N; k++) h[k] = hist_a[ch][k];
    exp_v = fir_ref(h, coef_a, 0, 32);
    t = 0;
    while (!a_m_valid && t < 40) begin
      if (mac_coef) begin
        a_coef_we = 1'b1; a_coef_addr = 4'($urandom_range(0, N - 1)); a_coef_wdata = 16'($urandom);
      end
      tick(); t++;
    end
    a_coef_we = 1'b0;
    check("a_latency", t, N + 2);
    for (int i = 0; i < stall; i++) begin
      check("a_hold_data", a_m_data, exp_v);
      check("a_hold_s_ready", a_s_ready, 0);
      tick();
    end
    check("a_m_valid", a_m_valid, 1);
    check("a_m_data", a_m_data, exp_v);
    check("a_m_chan", a_m_chan, ch);
    got = longint'(a_m_data);
    a_m_ready = 1'b1;
    tick();
    a_m_ready = 1'b0;
    check("a_m_valid_drop", a_m_valid, 0);
  endtask

  task automatic send_b(input int ch, input longint x, output longint got);
    int     t;
    longint exp_v;
    longint h [N];
    t = 0;
    while (!b_s_ready && t < 100) begin tick(); t++; end
    check("b_s_ready_idle", b_s_ready, 1);
    b_s_valid = 1'b1; b_s_chan = ch[1:0]; b_s_data = x[15:0];
    tick();
    b_s_valid = 1'b0;
    for (int k = N - 1; k > 0; k--) hist_b[ch][k] = hist_b[ch][k-1];
    hist_b[ch][0] = longint'($signed(b_s_data));
    for (int k = 0; k < N; k++) h[k] = hist_b[ch][k];
    exp_v = fir_ref(h, coef_b, 2, 16);
    t = 0;
    while (!b_m_valid && t < 40) begin tick(); t++; end
    check("b_latency", t, N + 2);
    check("b_m_data", b_m_data, exp_v);
    check("b_m_chan", b_m_chan, ch);
    got = longint'(b_m_data);
    b_m_ready = 1'b1;
    tick();
    b_m_ready = 1'b0;
  endtask

  task automatic impulse_a(input int ch);
    longint got;
    for (int i = 0; i < 12; i++) begin
      send_a(ch, (i == 0) ? 1 : 0, 0, 1'b0, got);
      check("a_impulse_tap", got, (i < N) ? cf[i] : 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int     t;
    int     mv;
    longint got;
    longint x;

    a_clear = 0; a_s_valid = 0; a_m_ready = 0; a_coef_we = 0;
    a_s_data = '0; a_s_chan = '0; a_coef_addr = '0; a_coef_wdata = '0;
    b_clear = 0; b_s_valid = 0; b_m_ready = 0; b_coef_we = 0;
    b_s_data = '0; b_s_chan = '0; b_coef_addr = '0; b_coef_wdata = '0;
    zero_hist();
    for (int k = 0; k < N; k++) begin coef_a[k] = 0; coef_b[k] = 0; end

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_s_ready", a_s_ready, 0);
    check("rst_m_valid", a_m_valid, 0);
    check("rst_m_data", a_m_data, 0);
    check("rst_m_chan", a_m_chan, 0);
    check("rst_chan_err", a_chan_err, 0);
    check("rst_busy", a_busy, 1);
    check("rst_b_m_data", b_m_data, 0);

    // Clear sweep after reset: CH*N cycles with s_ready low
    rst_n = 1'b1;
    t = 0; mv = 0;
    while (!a_s_ready && t < 100) begin
      tick(); t++;
      if (a_m_valid) mv++;
    end
    check("a_sweep_len", t, 2 * N);
    check("a_sweep_m_valid", mv, 0);
    check("a_idle_busy", a_busy, 0);

    // Fixed taps, with out-of-range addresses that must be ignored
    for (int k = 0; k < N; k++) load_a(k, cf[k]);
    load_a(11, 999);
    load_a(15, -7);
    impulse_a(0);

    // Interleaved constant inputs reach steady state
    for (int i = 0; i < N; i++) begin
      send_a(0, 1, 0, 1'b0, got);
      if (i == N - 1) check("a_steady_ch0", got, 36);
      send_a(1, 2, 0, 1'b0, got);
      if (i == N - 1) check("a_steady_ch1", got, 72);
    end

    // Output stall, and coefficient writes during MAC that must be dropped
    send_a(0, 5, 5, 1'b0, got);
    send_a(1, -3, 0, 1'b1, got);
    send_a(0, 9, 2, 1'b1, got);
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    zero_hist();
    check("a_clear_busy", a_busy, 1);
    impulse_a(1);

    // Clear while MAC is running: no result, histories zeroed
    wait_ready_a();
    a_s_valid = 1'b1; a_s_chan = 1'b0; a_s_data = 32'd77;
    tick();
    a_s_valid = 1'b0;
    repeat (5) tick();
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    zero_hist();
    mv = 0;
    for (int i = 0; i < 30; i++) begin
      if (a_m_valid) mv++;
      tick();
    end
    check("a_abort_m_valid", mv, 0);
    impulse_a(0);

    // Reset in the middle of MAC: no output, taps retained
    wait_ready_a();
    a_s_valid = 1'b1; a_s_chan = 1'b1; a_s_data = 32'd123;
    tick();
    a_s_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", a_m_valid, 0);
    check("midrst_s_ready", a_s_ready, 0);
    check("midrst_m_data", a_m_data, 0);
    tick();
    rst_n = 1'b1;
    zero_hist();
    impulse_a(0);

    // Randomized taps and samples
    for (int k = 0; k < N; k++) load_a(k, longint'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) x = longint'($signed($urandom));
      else x = longint'($urandom_range(0, 200)) - 100;
      send_a(int'($urandom_range(0, 1)), x, int'($urandom_range(0, 3)),
             1'(($urandom_range(0, 1))), got);
    end

    // DUT B: rounding shift
    t = 0;
    while (!b_s_ready && t < 100) begin tick(); t++; end
    load_b(0, 6);
    for (int k = 1; k < N; k++) load_b(k, 0);
    send_b(2, 1, got);
    check("b_round_pos", got, 2);
    send_b(2, -1, got);
    check("b_round_neg", got, -1);

    // DUT B: out-of-range channel is consumed and flagged
    check("b_bad_chan_ready", b_s_ready, 1);
    b_s_valid = 1'b1; b_s_chan = 2'd3; b_s_data = 16'd55;
    tick();
    b_s_valid = 1'b0;
    check("b_chan_err_pulse", b_chan_err, 1);
    tick();
    check("b_chan_err_drop", b_chan_err, 0);
    mv = 0;
    for (int i = 0; i < 20; i++) begin
      if (b_m_valid) mv++;
      tick();
    end
    check("b_bad_chan_no_out", mv, 0);
    check("b_bad_chan_idle", b_busy, 0);

    // DUT B: saturation at both rails
    for (int k = 0; k < N; k++) load_b(k, cf[k]);
    b_clear = 1'b1; tick(); b_clear = 1'b0;
    zero_hist();
    for (int i = 0; i < N; i++) send_b(0, 32767, got);
    check("b_sat_pos", got, 32767);
    for (int i = 0; i < N; i++) send_b(1, -32768, got);
    check("b_sat_neg", got, -32768);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
